// File: rtl/pcd8544_spi_receiver_pkg.sv
// Shared constants for the PCD8544-compatible serial responder: geometry,
// command opcodes, display-mode encodings and decoder states.
package pcd8544_spi_receiver_pkg;

  localparam int LCD_COLS  = 84;
  localparam int LCD_BANKS = 6;

  // Command opcodes; each is matched under the mask noted beside it
  localparam logic [7:0] OP_FSET = 8'h20;  // mask F8: 0010_0PVH
  localparam logic [7:0] OP_DCTL = 8'h08;  // mask FA: 0000_1D0E
  localparam logic [7:0] OP_SETY = 8'h40;  // mask F8: 0100_0YYY
  localparam logic [7:0] OP_SETX = 8'h80;  // mask 80: 1XXX_XXXX (H=0)
  localparam logic [7:0] OP_TC   = 8'h04;  // mask FC: 0000_01TT (H=1)
  localparam logic [7:0] OP_BIAS = 8'h10;  // mask F8: 0001_0BBB (H=1)

  // disp_mode = {D,E}
  localparam logic [1:0] DM_BLANK   = 2'b00;
  localparam logic [1:0] DM_NORMAL  = 2'b10;
  localparam logic [1:0] DM_ALL_ON  = 2'b01;
  localparam logic [1:0] DM_INVERSE = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_DECODE = 1'b1
  } state_t;

endpackage

// File: rtl/pcd8544_spi_receiver_spi_rx_shifter.sv
// Serial front end: synchronizes the SPI pins into the system clock domain,
// detects sclk rising edges while selected and assembles MSB-first bytes.
module spi_rx_shifter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       sce,
  input  logic       dc,
  input  logic       rst,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       rst_sync
);

  // Bit order inside each synchronizer word: {rst, dc, sce, mosi, sclk}.
  // sce resets high (deselected), everything else low.
  localparam logic [4:0] SYNC_RST = 5'b00100;

  logic [4:0] sync_chain [SYNC_STAGES];
  logic [4:0] pins_s;
  logic       sclk_d, sce_d;
  logic       sclk_rise, sce_rise;
  logic [6:0] sh;
  logic [2:0] bitcnt;

  assign pins_s    = sync_chain[SYNC_STAGES-1];
  assign rst_sync  = pins_s[4];
  assign sclk_rise = pins_s[0] & ~sclk_d & ~pins_s[2];
  assign sce_rise  = pins_s[2] & ~sce_d;

  // Multi-flop synchronizer chain for all five serial inputs
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_chain[i] <= SYNC_RST;
    end else begin
      sync_chain[0] <= {rst, dc, sce, mosi, sclk};
      for (int i = 1; i < SYNC_STAGES; i++) sync_chain[i] <= sync_chain[i-1];
    end
  end

  // Delayed copies of sclk/sce for edge detection; tracked even in soft reset
  // so leaving soft reset with sclk high does not fake a rising edge
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      sclk_d <= 1'b0;
      sce_d  <= 1'b1;
    end else begin
      sclk_d <= pins_s[0];
      sce_d  <= pins_s[2];
    end
  end

  // Shift register, bit counter and completed-byte register
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      sh       <= '0;
      bitcnt   <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
      rx_dc    <= 1'b0;
    end else if (!rst_sync) begin
      sh       <= '0;
      bitcnt   <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
      rx_dc    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (sce_rise) begin
        // Deselect drops any partial byte
        bitcnt <= '0;
      end else if (sclk_rise) begin
        sh     <= {sh[5:0], pins_s[1]};
        bitcnt <= bitcnt + 3'd1;
        if (bitcnt == 3'd7) begin
          rx_valid <= 1'b1;
          rx_byte  <= {sh, pins_s[1]};
          rx_dc    <= pins_s[3];
        end
      end
    end
  end

endmodule

// File: rtl/pcd8544_spi_receiver.sv
// PCD8544-compatible display-side responder: decodes completed SPI bytes into
// controller state and turns data bytes into frame-RAM writes.
module pcd8544_spi_receiver
  import pcd8544_spi_receiver_pkg::*;
#(
  parameter int COLS        = LCD_COLS,
  parameter int BANKS       = LCD_BANKS,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       sce,
  input  logic       dc,
  input  logic       rst,
  output logic       wr_en,
  output logic [8:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic [6:0] cur_x,
  output logic [2:0] cur_y,
  output logic       h_ext,
  output logic       v_addr,
  output logic       pd,
  output logic [1:0] disp_mode,
  output logic [6:0] vop,
  output logic [2:0] bias,
  output logic [1:0] tc,
  output logic       cmd_err
);

  localparam logic [6:0] X_MAX = 7'(COLS - 1);
  localparam logic [2:0] Y_MAX = 3'(BANKS - 1);

  logic   rst_sync;
  state_t state, state_nx;
  logic [6:0] x_nx, vop_nx;
  logic [2:0] y_nx, bias_nx;
  logic [1:0] dm_nx, tc_nx;
  logic       h_nx, v_nx, pd_nx;

  spi_rx_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_shifter (
    .clock    (clock),
    .Reset    (Reset),
    .sclk     (sclk),
    .mosi     (mosi),
    .sce      (sce),
    .dc       (dc),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .rx_dc    (rx_dc),
    .rst_sync (rst_sync)
  );

  assign wr_addr = 9'(cur_y) * 9'(COLS) + 9'(cur_x);
  assign wr_data = rx_byte;

  // Controller state; both resets restore the power-on values
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state <= ST_IDLE;
      cur_x <= '0;  cur_y <= '0;
      h_ext <= 1'b0; v_addr <= 1'b0; pd <= 1'b1;
      disp_mode <= DM_BLANK;
      vop <= '0; bias <= '0; tc <= '0;
    end else if (!rst_sync) begin
      state <= ST_IDLE;
      cur_x <= '0;  cur_y <= '0;
      h_ext <= 1'b0; v_addr <= 1'b0; pd <= 1'b1;
      disp_mode <= DM_BLANK;
      vop <= '0; bias <= '0; tc <= '0;
    end else begin
      state <= state_nx;
      cur_x <= x_nx;  cur_y <= y_nx;
      h_ext <= h_nx;  v_addr <= v_nx; pd <= pd_nx;
      disp_mode <= dm_nx;
      vop <= vop_nx; bias <= bias_nx; tc <= tc_nx;
    end
  end

  // Decode the held byte for one cycle after each rx_valid pulse
  always_comb begin
    state_nx = state;
    x_nx = cur_x;  y_nx = cur_y;
    h_nx = h_ext;  v_nx = v_addr; pd_nx = pd;
    dm_nx = disp_mode;
    vop_nx = vop; bias_nx = bias; tc_nx = tc;
    wr_en   = 1'b0;
    cmd_err = 1'b0;
    case (state)
      ST_IDLE: if (rx_valid) state_nx = ST_DECODE;
      ST_DECODE: begin
        state_nx = ST_IDLE;
        if (rx_dc) begin
          wr_en = 1'b1;
          if (!v_addr) begin
            if (cur_x == X_MAX) begin
              x_nx = '0;
              y_nx = (cur_y == Y_MAX) ? 3'd0 : cur_y + 3'd1;
            end else begin
              x_nx = cur_x + 7'd1;
            end
          end else begin
            if (cur_y == Y_MAX) begin
              y_nx = '0;
              x_nx = (cur_x == X_MAX) ? 7'd0 : cur_x + 7'd1;
            end else begin
              y_nx = cur_y + 3'd1;
            end
          end
        end else if ((rx_byte & 8'hF8) == OP_FSET) begin
          {pd_nx, v_nx, h_nx} = rx_byte[2:0];
        end else if (rx_byte == 8'h00) begin
          // NOP
        end else if (!h_ext) begin
          if ((rx_byte & 8'hFA) == OP_DCTL)      dm_nx = {rx_byte[2], rx_byte[0]};
          else if ((rx_byte & 8'hF8) == OP_SETY) begin
            if (rx_byte[2:0] <= Y_MAX) y_nx = rx_byte[2:0];
            else                       cmd_err = 1'b1;
          end else if ((rx_byte & 8'h80) == OP_SETX) begin
            if (rx_byte[6:0] <= X_MAX) x_nx = rx_byte[6:0];
            else                       cmd_err = 1'b1;
          end else cmd_err = 1'b1;
        end else begin
          if ((rx_byte & 8'hFC) == OP_TC)             tc_nx   = rx_byte[1:0];
          else if ((rx_byte & 8'hF8) == OP_BIAS)      bias_nx = rx_byte[2:0];
          else if ((rx_byte & 8'h80) == OP_SETX)      vop_nx  = rx_byte[6:0];
          else                                        cmd_err = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pcd8544_spi_receiver.sv
// Scoreboard bench for pcd8544_spi_receiver: expected bytes and RAM writes are
// queued as stimulus is sent and popped by a monitor when the DUT produces them.
module tb_pcd8544_spi_receiver;

  localparam time HALF = 50ns;  // sclk phase: 5 system clocks

  logic clock = 1'b0, Reset = 1'b0;
  logic sclk = 1'b0, mosi = 1'b0, sce = 1'b1, dc = 1'b0, rst = 1'b1;
  logic       wr_en, rx_valid, rx_dc, h_ext, v_addr, pd, cmd_err;
  logic [8:0] wr_addr;
  logic [7:0] wr_data, rx_byte;
  logic [6:0] cur_x, vop;
  logic [2:0] cur_y, bias;
  logic [1:0] disp_mode, tc;

  int vectors = 0, miscompares = 0;
  int err_cnt = 0, cyc = 0, last_rx_cyc = -10;
  logic [8:0]  rx_q [$];
  logic [16:0] wr_q [$];

  pcd8544_spi_receiver dut (
    .clock(clock), .Reset(Reset), .sclk(sclk), .mosi(mosi), .sce(sce), .dc(dc), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_dc(rx_dc),
    .cur_x(cur_x), .cur_y(cur_y), .h_ext(h_ext), .v_addr(v_addr), .pd(pd),
    .disp_mode(disp_mode), .vop(vop), .bias(bias), .tc(tc), .cmd_err(cmd_err)
  );

  always #5ns clock = ~clock;

  always @(posedge clock) cyc++;

  // Monitor: pop scoreboard entries as the DUT emits bytes and writes
  always @(negedge clock) begin
    logic [8:0]  er;
    logic [16:0] ew;
    if (rx_valid) begin
      vectors++;
      if (rx_q.size() == 0) begin
        miscompares++;
        $display("FAIL rx_unexpected: got dc=%0b byte=%02h, none queued", rx_dc, rx_byte);
      end else begin
        er = rx_q.pop_front();
        if ({rx_dc, rx_byte} !== er) begin
          miscompares++;
          $display("FAIL rx_byte: got dc=%0b %02h, want dc=%0b %02h", rx_dc, rx_byte, er[8], er[7:0]);
        end
      end
      last_rx_cyc = cyc;
    end
    if (wr_en) begin
      vectors++;
      if (wr_q.size() == 0) begin
        miscompares++;
        $display("FAIL wr_unexpected: got addr=%0d data=%02h, none queued", wr_addr, wr_data);
      end else begin
        ew = wr_q.pop_front();
        if ({wr_addr, wr_data} !== ew || cyc != last_rx_cyc + 1) begin
          miscompares++;
          $display("FAIL wr: got addr=%0d data=%02h lat=%0d, want addr=%0d data=%02h lat=1",
                   wr_addr, wr_data, cyc - last_rx_cyc, ew[16:8], ew[7:0]);
        end
      end
    end
    if (cmd_err) err_cnt++;
  end

  task automatic spi_bits(input logic [7:0] b, input logic d, input int n);
    sce = 1'b0;
    for (int i = 7; i > 7 - n; i--) begin
      sclk = 1'b0; mosi = b[i]; dc = d;
      #(HALF);
      sclk = 1'b1;
      #(HALF);
    end
    sclk = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic d);
    rx_q.push_back({d, b});
    spi_bits(b, d, 8);
  endtask

  task automatic deselect();
    #(HALF);
    sce = 1'b1;
    #(2 * HALF);
  endtask

  task automatic check_drained(input string tag);
    vectors++;
    if (rx_q.size() != 0 || wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drained: got rx_left=%0d wr_left=%0d, want 0/0", tag, rx_q.size(), wr_q.size());
    end
  endtask

  task automatic check_xy(input string tag, input logic [6:0] x, input logic [2:0] y);
    vectors++;
    if (cur_x !== x || cur_y !== y) begin
      miscompares++;
      $display("FAIL %s_xy: got (%0d,%0d), want (%0d,%0d)", tag, cur_x, cur_y, x, y);
    end
  endtask

  task automatic check_errs(input string tag, input int base, input int n);
    vectors++;
    if (err_cnt - base != n) begin
      miscompares++;
      $display("FAIL %s_cmd_err: got %0d pulses, want %0d", tag, err_cnt - base, n);
    end
  endtask

  task automatic test_reset();
    #23ns;
    vectors++;
    if (pd !== 1'b1 || disp_mode !== 2'b00 || cur_x !== 7'd0 || cur_y !== 3'd0 ||
        wr_en !== 1'b0 || rx_valid !== 1'b0 || cmd_err !== 1'b0 || vop !== 7'd0 || h_ext !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got pd=%0b dm=%b x=%0d y=%0d wr=%0b rxv=%0b vop=%0d, want 1 00 0 0 0 0 0",
               pd, disp_mode, cur_x, cur_y, wr_en, rx_valid, vop);
    end
    Reset = 1'b1;
    repeat (20) @(posedge clock);
    #1ns;
    check_xy("reset", 7'd0, 3'd0);
    vectors++;
    if (pd !== 1'b1 || disp_mode !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_idle: got pd=%0b dm=%b, want pd=1 dm=00", pd, disp_mode);
    end
    check_errs("reset", 0, 0);
  endtask

  task automatic test_init();
    int e0 = err_cnt;
    send(8'h21, 1'b0); send(8'h90, 1'b0); send(8'h20, 1'b0); send(8'h0C, 1'b0);
    deselect();
    vectors++;
    if (vop !== 7'h10 || h_ext !== 1'b0 || pd !== 1'b0 || v_addr !== 1'b0 || disp_mode !== 2'b10) begin
      miscompares++;
      $display("FAIL init_regs: got vop=%02h h=%0b pd=%0b v=%0b dm=%b, want 10 0 0 0 10",
               vop, h_ext, pd, v_addr, disp_mode);
    end
    check_errs("init", e0, 0);
    check_drained("init");
  endtask

  task automatic test_data_horizontal();
    send(8'h80 | 8'd83, 1'b0); send(8'h40 | 8'd5, 1'b0);
    wr_q.push_back({9'd503, 8'hAA}); send(8'hAA, 1'b1);
    wr_q.push_back({9'd0,   8'h55}); send(8'h55, 1'b1);
    deselect();
    check_xy("horiz", 7'd1, 3'd0);
    check_drained("horiz");
  endtask

  task automatic test_data_vertical();
    send(8'h22, 1'b0); send(8'h80 | 8'd2, 1'b0); send(8'h40 | 8'd5, 1'b0);
    wr_q.push_back({9'd422, 8'h0F}); send(8'h0F, 1'b1);
    wr_q.push_back({9'd3,   8'h0F}); send(8'h0F, 1'b1);
    deselect();
    check_xy("vert", 7'd3, 3'd1);
    check_drained("vert");
  endtask

  task automatic test_illegal();
    int e0 = err_cnt;
    send(8'h40 | 8'd6, 1'b0); send(8'h80 | 8'd84, 1'b0);
    deselect();
    check_errs("illegal", e0, 2);
    check_xy("illegal", 7'd3, 3'd1);
    e0 = err_cnt;
    send(8'hA1, 1'b0);
    deselect();
    check_errs("setx33", e0, 0);
    check_xy("setx33", 7'd33, 3'd1);
    check_drained("illegal");
  endtask

  task automatic test_partial();
    int e0 = err_cnt;
    spi_bits(8'hFF, 1'b0, 5);
    deselect();
    send(8'hF0, 1'b0);           // H=0: SETX with X=112 is out of range
    deselect();
    vectors++;
    if (rx_byte !== 8'hF0) begin
      miscompares++;
      $display("FAIL partial_byte: got %02h, want f0", rx_byte);
    end
    check_errs("partial", e0, 1);
    check_xy("partial", 7'd33, 3'd1);
    check_drained("partial");
  endtask

  task automatic test_soft_reset();
    int e0;
    spi_bits(8'hC3, 1'b0, 4);
    rst = 1'b0;
    #(2 * HALF);
    spi_bits(8'hFF, 1'b0, 8);    // ignored while rst is low
    #(HALF);
    vectors++;
    if (pd !== 1'b1 || disp_mode !== 2'b00 || vop !== 7'd0 || v_addr !== 1'b0 ||
        h_ext !== 1'b0 || cur_x !== 7'd0 || cur_y !== 3'd0 || rx_byte !== 8'd0) begin
      miscompares++;
      $display("FAIL softrst_state: got pd=%0b dm=%b vop=%0d v=%0b h=%0b x=%0d y=%0d rxb=%02h, want 1 00 0 0 0 0 0 00",
               pd, disp_mode, vop, v_addr, h_ext, cur_x, cur_y, rx_byte);
    end
    rst = 1'b1;
    #(2 * HALF);
    e0 = err_cnt;
    send(8'h21, 1'b0); send(8'h13, 1'b0); send(8'h05, 1'b0);
    deselect();
    vectors++;
    if (h_ext !== 1'b1 || pd !== 1'b0 || bias !== 3'd3 || tc !== 2'd1) begin
      miscompares++;
      $display("FAIL softrst_after: got h=%0b pd=%0b bias=%0d tc=%0d, want 1 0 3 1", h_ext, pd, bias, tc);
    end
    check_errs("softrst", e0, 0);
    check_drained("softrst");
  endtask

  initial begin
    test_reset();
    test_init();
    test_data_horizontal();
    test_data_vertical();
    test_illegal();
    test_partial();
    test_soft_reset();
    repeat (10) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: got no end of run, want completion");
    $fatal(1);
  end

endmodule
